// File: rtl/local_history_unit.sv
// Per-branch local history table with registered lookup, speculative shift-in, mispredict repair and a strided flush engine.
// Optional LHU_STATS_EN adds saturating counters of accepted speculative writes and repairs.
module local_history_unit #(
    parameter int INDEX_LEN    = 7,
    parameter int HISTORY_LEN  = 10,
    parameter int FLUSH_STRIDE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lookup_valid,
    input  logic [INDEX_LEN-1:0]   lookup_idx,
    output logic [HISTORY_LEN-1:0] lookup_hist,
    output logic                   lookup_hit,
    input  logic                   spec_valid,
    input  logic [INDEX_LEN-1:0]   spec_idx,
    input  logic                   spec_taken,
    input  logic                   res_valid,
    input  logic [INDEX_LEN-1:0]   res_idx,
    input  logic [HISTORY_LEN-1:0] res_hist,
    input  logic                   res_taken,
    input  logic                   res_mispredict,
    input  logic                   flush,
    output logic                   busy
`ifdef LHU_STATS_EN
    ,
    output logic [15:0]            stat_spec,
    output logic [15:0]            stat_repair
`endif
);

    localparam int LOCATIONS  = 2 ** INDEX_LEN;
    localparam int GROUPS     = LOCATIONS / FLUSH_STRIDE;
    localparam int CNT_W      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int STRIDE_LOG = $clog2(FLUSH_STRIDE);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HISTORY_LEN-1:0] hist_q [LOCATIONS];
    logic [HISTORY_LEN-1:0] hist_d [LOCATIONS];
    logic [LOCATIONS-1:0]   valid_q, valid_d;
    logic [HISTORY_LEN-1:0] lookup_hist_q, lookup_hist_d;
    logic                   lookup_hit_q, lookup_hit_d;

    logic                   repair_en;
    logic                   spec_en;
    logic [HISTORY_LEN-1:0] spec_old;
    logic [INDEX_LEN-1:0]   flush_base;
    logic                   res_hist_msb_unused;

    // The repair history drops the oldest bit of the snapshot, so its MSB never matters.
    assign res_hist_msb_unused = res_hist[HISTORY_LEN-1];

    assign repair_en  = (state_q == IDLE) && res_valid && res_mispredict;
    assign spec_en    = (state_q == IDLE) && spec_valid && !(repair_en && (spec_idx == res_idx));
    assign spec_old   = hist_q[spec_idx];
    assign flush_base = INDEX_LEN'(cnt_q) << STRIDE_LOG;

`ifdef LHU_STATS_EN
    logic [15:0] stat_spec_q, stat_spec_d;
    logic [15:0] stat_repair_q, stat_repair_d;

    always_comb begin
        stat_spec_d   = stat_spec_q;
        stat_repair_d = stat_repair_q;
        if (spec_en && (stat_spec_q != 16'hFFFF)) begin
            stat_spec_d = stat_spec_q + 16'd1;
        end
        if (repair_en && (stat_repair_q != 16'hFFFF)) begin
            stat_repair_d = stat_repair_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_spec_q   <= '0;
            stat_repair_q <= '0;
        end else begin
            stat_spec_q   <= stat_spec_d;
            stat_repair_q <= stat_repair_d;
        end
    end

    assign stat_spec   = stat_spec_q;
    assign stat_repair = stat_repair_q;
`endif

    // Lookup reads the array as it stood before this cycle's writes.
    always_comb begin
        lookup_hist_d = lookup_hist_q;
        lookup_hit_d  = lookup_hit_q;
        if (lookup_valid) begin
            if ((state_q == FLUSH) || !valid_q[lookup_idx]) begin
                lookup_hist_d = '0;
                lookup_hit_d  = 1'b0;
            end else begin
                lookup_hist_d = hist_q[lookup_idx];
                lookup_hit_d  = 1'b1;
            end
        end
    end

    always_comb begin
        logic [INDEX_LEN-1:0] fidx;
        state_d = state_q;
        cnt_d   = cnt_q;
        hist_d  = hist_q;
        valid_d = valid_q;
        fidx    = '0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
                // Repair is applied last so it overrides a same-index speculative write.
                if (spec_en) begin
                    hist_d[spec_idx]  = {spec_old[HISTORY_LEN-2:0], spec_taken};
                    valid_d[spec_idx] = 1'b1;
                end
                if (repair_en) begin
                    hist_d[res_idx]  = {res_hist[HISTORY_LEN-2:0], res_taken};
                    valid_d[res_idx] = 1'b1;
                end
            end
            FLUSH: begin
                for (int j = 0; j < FLUSH_STRIDE; j++) begin
                    fidx          = flush_base + INDEX_LEN'(j);
                    hist_d[fidx]  = '0;
                    valid_d[fidx] = 1'b0;
                end
                if (cnt_q == CNT_W'(GROUPS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hist_q        <= '{default: '0};
            valid_q       <= '0;
            lookup_hist_q <= '0;
            lookup_hit_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hist_q        <= hist_d;
            valid_q       <= valid_d;
            lookup_hist_q <= lookup_hist_d;
            lookup_hit_q  <= lookup_hit_d;
        end
    end

    assign lookup_hist = lookup_hist_q;
    assign lookup_hit  = lookup_hit_q;
    assign busy        = (state_q == FLUSH);

endmodule

// File: doc/local_history_unit.md
Name: local_history_unit

Overview:
Parametrised successor to the per-branch local history table in the branch predictor. Indexed by PC bits, it adds three things:
- a registered lookup port that also reports entry validity;
- a speculative update port that shifts the predicted direction in at predict time;
- a resolve/repair port that rewrites history on a mispredict, plus a multi-cycle flush engine.
It sits between fetch (lookup/speculate) and the branch resolve stage (repair).

Parameters:
INDEX_LEN, 7, PC index bits; LOCATIONS = 2**INDEX_LEN entries
HISTORY_LEN, 10, history bits per entry (>=2)
FLUSH_STRIDE, 4, entries cleared per flush cycle; power of 2, divides LOCATIONS

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
lookup_valid  in  1  lookup request
lookup_idx  in  INDEX_LEN  entry to read
lookup_hist  out  HISTORY_LEN  registered history of looked-up entry
lookup_hit  out  1  registered valid bit of looked-up entry
spec_valid  in  1  speculative update request
spec_idx  in  INDEX_LEN  entry to shift
spec_taken  in  1  predicted direction
res_valid  in  1  branch resolved
res_idx  in  INDEX_LEN  entry of resolved branch
res_hist  in  HISTORY_LEN  history snapshot taken at lookup (pre-speculation)
res_taken  in  1  actual direction
res_mispredict  in  1  prediction was wrong
flush  in  1  start bulk invalidate (pulse)
busy  out  1  flush in progress

Behaviour:
- Storage: LOCATIONS entries, each HISTORY_LEN bits plus a valid bit. Shift rule: new = {old[HISTORY_LEN-2:0], bit}; LSB is the newest outcome.
- Reset (reset=0, async): all entries and valid bits 0, lookup_hist=0, lookup_hit=0, busy=0, FSM to IDLE, flush counter 0. Reset mid-flush aborts the flush; the array is cleared anyway.
- Lookup: latency 1. The array is sampled before same-cycle writes (read-before-write).
  - When lookup_valid=1, the next edge loads lookup_hist=entry and lookup_hit=valid.
  - Invalid entry: lookup_hist=0, lookup_hit=0.
  - When lookup_valid=0, outputs hold.
- Speculative update: spec_valid=1 in IDLE writes entry[spec_idx] = shift(entry, spec_taken) and sets valid.
- Resolve:
  - res_valid=1 with res_mispredict=1 in IDLE writes entry[res_idx] = {res_hist[HISTORY_LEN-2:0], res_taken} and sets valid. This discards any younger speculation on that entry.
  - res_mispredict=0 causes no write.
- Simultaneous spec and repair:
  - same index: repair wins; the speculative write is dropped.
  - different indices: both writes happen.
- Flush FSM, states IDLE and FLUSH:
  - IDLE → FLUSH on flush=1; counter=0.
  - In FLUSH, each cycle clears entries counter*FLUSH_STRIDE … +FLUSH_STRIDE-1 (history and valid bits), then counter++.
  - FLUSH → IDLE after the cycle clearing the last group: LOCATIONS/FLUSH_STRIDE cycles; counter wraps to 0.
  - busy=1 exactly while in FLUSH, registered: it rises the edge after flush is sampled.
  - flush while busy is ignored.
- While busy=1:
  - spec and resolve writes are dropped (not queued);
  - lookups still register, but return lookup_hist=0, lookup_hit=0.
- All index inputs are full width, so there is no out-of-range case.

Optional Feature:
LHU_STATS_EN
- Defined: adds outputs stat_spec [15:0] and stat_repair [15:0].
  - stat_spec counts accepted speculative writes; stat_repair counts accepted repairs.
  - Both saturate at 16'hFFFF, are cleared by reset, and are not cleared by flush.
  - A speculative write dropped due to a same-index repair is not counted.
- Undefined: ports and counters are absent; remaining behaviour is identical.

Test Plan:
- Reset, then lookup idx 5 → next cycle lookup_hist=0, lookup_hit=0, busy=0.
- Spec idx 5 with taken 1,1,0,1 over four cycles, then lookup idx 5 → lookup_hist=10'b0000001101, lookup_hit=1.
- Read-before-write: same cycle spec idx 9 taken=1 and lookup idx 9 on a fresh entry → lookup_hist=0, lookup_hit=0. Lookup again next cycle → 10'b0000000001, lookup_hit=1.
- Repair priority: entry 3=10'b0000000111. Same cycle spec idx 3 taken=1 and res idx 3, res_hist=10'b0000000011, res_taken=0, mispredict=1 → entry 3=10'b0000000110. With LHU_STATS_EN: stat_repair=1, stat_spec unchanged.
- Flush, defaults: pulse flush → busy high for exactly 32 cycles. Spec idx 0 during busy is dropped. Afterwards all entries read lookup_hit=0, lookup_hist=0. A flush pulse at busy cycle 10 does not extend busy.
- Async reset mid-flush: assert reset=0 at flush cycle 7 → busy=0 immediately and all outputs 0. After release, lookups return 0/0 and spec writes are accepted on the first cycle.
